fifo_rd_check: RTL
==================

// Module: fifo_rd_check
// PURPOSE
//  Downstream consumer of the byte FIFO (fifod) loopback test. Pops the FIFO whenever data is
//  available and checks the stream against an incrementing pattern (BASE, BASE+1, ...).
//  Reports received count, error count, timeout and a pass/done verdict to the test harness.
//  Accounts for the FIFO's 1-cycle read latency (dout valid the cycle after rd_en).
// PARAMETERS
//  DW       8      data width of FIFO dout
//  NUM      16     bytes to read per run (1..255)
//  BASE     8'h40  expected value of first byte
//  TIMEOUT  64     consecutive empty cycles in READ before aborting (>=1)
// PORTS
//  clk         in   1   clock, shared with FIFO rd_clk
//  rst         in   1   reset, asynchronous, active-high
//  start       in   1   run request; sampled in IDLE and DONE only
//  fifo_empty  in   1   FIFO empty flag
//  fifo_dout   in   DW  FIFO read data, valid 1 cycle after fifo_rd_en
//  fifo_rd_en  out  1   FIFO pop strobe
//  busy        out  1   high in READ and DRAIN
//  done        out  1   high in DONE
//  pass        out  1   done & err_cnt==0 & !timeout & rx_cnt==NUM
//  timeout     out  1   run aborted by TIMEOUT; held until next start/reset
//  rx_cnt      out  8   bytes checked this run
//  err_cnt     out  8   mismatching bytes, saturates at 8'hFF
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal issued cnt, expected=BASE, valid pipe, idle cnt cleared.
//  States: IDLE, READ, DRAIN, DONE.
//   IDLE : start -> READ; clear rx_cnt, err_cnt, timeout, issued, idle cnt; expected<=BASE.
//   READ : fifo_rd_en = !fifo_empty & (issued<NUM) (combinational, gated by registered state).
//          Each rd_en: issued++. Cycle that issues byte NUM -> DRAIN next.
//          Empty cycles increment idle cnt; rd_en clears it; idle cnt==TIMEOUT-1 on an empty
//          cycle -> timeout<=1, -> DRAIN.
//   DRAIN: fifo_rd_en=0; waits for valid pipe to empty (max 1 cycle) -> DONE.
//   DONE : done=1; pass as defined; start -> READ with same clears as IDLE.
//  Check pipe: rd_vld <= fifo_rd_en. When rd_vld: compare fifo_dout to expected;
//   mismatch -> err_cnt++ (sat); expected <= expected+1 mod 2^DW; rx_cnt++.
//   Check happens in the cycle after the pop, including a pop on the final READ cycle (in DRAIN).
//  Never pops while fifo_empty=1; never pops more than NUM bytes per run.
//  start in READ/DRAIN ignored. start and last pop same cycle: no effect.
//  rst mid-run: fifo_rd_en drops immediately (async), all state/counters cleared; any popped
//   but unchecked byte is discarded.
//  Latency: first rd_en the cycle after start if FIFO non-empty; done asserts 2 cycles after
//   the last rd_en.
// TESTING
//  1 Preload 0x40..0x4F, pulse start -> rd_en 16 consecutive cycles, done, pass=1, rx_cnt=16, err_cnt=0.
//  2 Preload with byte 5 = 0x00 -> done, rx_cnt=16, err_cnt=1, pass=0, timeout=0.
//  3 Feed 16 bytes with random empty gaps (<TIMEOUT) -> rd_en never high while empty; result as 1.
//  4 Preload 10 bytes, TIMEOUT=64 -> timeout=1 after 64 empty cycles, rx_cnt=10, pass=0.
//  5 rst at rx_cnt=7 -> all outputs 0 same cycle; restart with fresh 16 bytes -> pass=1.
//  6 start pulsed mid-READ ignored; start in DONE restarts with counters cleared, expected=0x40.

Source files
------------

// File: rtl/fifo_rd_check.sv
// Read-side checker for the byte FIFO loopback test: pops the FIFO, checks an incrementing
// pattern starting at BASE, and reports counts, timeout and a pass/done verdict.
module fifo_rd_check #(
    parameter int            DW      = 8,
    parameter int            NUM     = 16,
    parameter logic [DW-1:0] BASE    = 8'h40,
    parameter int            TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          fifo_empty_i,
    input  logic [DW-1:0] fifo_dout_i,
    output logic          fifo_rd_en_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          pass_o,
    output logic          timeout_o,
    output logic [7:0]    rx_cnt_o,
    output logic [7:0]    err_cnt_o
);

    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      issued_q, issued_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic            rd_vld_q, rd_vld_d;
    logic [DW-1:0]   expected_q, expected_d;
    logic [7:0]      rx_cnt_q, rx_cnt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            timeout_q, timeout_d;
    logic            rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            idle_q     <= '0;
            rd_vld_q   <= 1'b0;
            expected_q <= BASE;
            rx_cnt_q   <= '0;
            err_cnt_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            idle_q     <= idle_d;
            rd_vld_q   <= rd_vld_d;
            expected_q <= expected_d;
            rx_cnt_q   <= rx_cnt_d;
            err_cnt_q  <= err_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        idle_d     = idle_q;
        expected_d = expected_q;
        rx_cnt_d   = rx_cnt_q;
        err_cnt_d  = err_cnt_q;
        timeout_d  = timeout_q;

        rd_en    = (state_q == READ) && !fifo_empty_i && (issued_q < 8'(NUM));
        rd_vld_d = rd_en;

        // FIFO data arrives one cycle after the pop, so the check trails rd_en by one cycle
        if (rd_vld_q) begin
            if ((fifo_dout_i != expected_q) && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            expected_d = expected_q + 1'b1;
            rx_cnt_d   = rx_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d    = READ;
                    issued_d   = '0;
                    idle_d     = '0;
                    expected_d = BASE;
                    rx_cnt_d   = '0;
                    err_cnt_d  = '0;
                    timeout_d  = 1'b0;
                end
            end
            READ: begin
                if (rd_en) begin
                    issued_d = issued_q + 8'd1;
                    idle_d   = '0;
                    if (issued_q == 8'(NUM - 1)) begin
                        state_d = DRAIN;
                    end
                end else if (idle_q == IW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            // No pops in DRAIN, so the one possible in-flight byte is checked here
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign fifo_rd_en_o = rd_en;
    assign busy_o       = (state_q == READ) || (state_q == DRAIN);
    assign done_o       = (state_q == DONE);
    assign pass_o       = done_o && (err_cnt_q == 8'd0) && !timeout_q && (rx_cnt_q == 8'(NUM));
    assign timeout_o    = timeout_q;
    assign rx_cnt_o     = rx_cnt_q;
    assign err_cnt_o    = err_cnt_q;

endmodule
